// File: rtl/iq_mix_integrate.sv
// IQ mixer and integrate-and-dump decimator: multiplies ADC samples by NCO cos/sin,
// truncates to MW bits and sums over a programmable window with saturating accumulators.
module iq_mix_integrate #(
  parameter int MPR   = 14,
  parameter int DW    = 14,
  parameter int MW    = 15,
  parameter int ACCW  = 32,
  parameter int CNTW  = 16,
  parameter int DEC_N = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clken,
  input  logic signed [DW-1:0]   adc_i,
  input  logic signed [MPR-1:0]  fsin_i,
  input  logic signed [MPR-1:0]  fcos_i,
  input  logic                   nco_valid,
  input  logic        [CNTW-1:0] dec_len,
  output logic signed [ACCW-1:0] i_o,
  output logic signed [ACCW-1:0] q_o,
  output logic                   out_valid,
  output logic                   ovf_o
);

  localparam int PW = DW + MPR;
  localparam int SH = PW - MW;
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic signed [DW-1:0]   adc_q, adc_d;
  logic signed [MPR-1:0]  fsin_q, fsin_d, fcos_q, fcos_d;
  logic                   v1_q, v1_d;
  logic signed [MW-1:0]   pi_q, pi_d, pq_q, pq_d;
  logic                   v2_q, v2_d;
  logic signed [ACCW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNTW-1:0]        cnt_q, cnt_d, len_q, len_d;
  logic                   sat_w_q, sat_w_d;
  logic signed [ACCW-1:0] i_q, i_d, q_q, q_d;
  logic                   ov_q, ov_d, ovf_q, ovf_d;

  logic signed [PW-1:0]   prod_i, prod_q, sh_i, sh_q;
  logic signed [ACCW-1:0] ext_i, ext_q, res_i, res_q;
  logic [ACCW:0]          sum_i, sum_q;
  logic                   sat_i, sat_q, take, last;

  assign prod_i = adc_q * fcos_q;
  assign prod_q = adc_q * fsin_q;
  assign sh_i   = prod_i >>> SH;
  assign sh_q   = prod_q >>> SH;

  // One extra guard bit: overflow shows up as disagreement between the top two bits.
  assign ext_i = {{(ACCW-MW){pi_q[MW-1]}}, pi_q};
  assign ext_q = {{(ACCW-MW){pq_q[MW-1]}}, pq_q};
  assign sum_i = {acc_i_q[ACCW-1], acc_i_q} + {ext_i[ACCW-1], ext_i};
  assign sum_q = {acc_q_q[ACCW-1], acc_q_q} + {ext_q[ACCW-1], ext_q};
  assign sat_i = sum_i[ACCW] ^ sum_i[ACCW-1];
  assign sat_q = sum_q[ACCW] ^ sum_q[ACCW-1];
  assign res_i = sat_i ? (sum_i[ACCW] ? ACC_MIN : ACC_MAX) : sum_i[ACCW-1:0];
  assign res_q = sat_q ? (sum_q[ACCW] ? ACC_MIN : ACC_MAX) : sum_q[ACCW-1:0];

  assign take = clken & v2_q;
  assign last = (cnt_q == len_q - CNTW'(1));

  always_comb begin
    adc_d   = adc_q;
    fsin_d  = fsin_q;
    fcos_d  = fcos_q;
    v1_d    = v1_q;
    pi_d    = pi_q;
    pq_d    = pq_q;
    v2_d    = v2_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_w_d = sat_w_q;
    i_d     = i_q;
    q_d     = q_q;
    ov_d    = ov_q;
    ovf_d   = ovf_q;
    if (clken) begin
      adc_d  = adc_i;
      fsin_d = fsin_i;
      fcos_d = fcos_i;
      v1_d   = nco_valid;
      pi_d   = sh_i[MW-1:0];
      pq_d   = sh_q[MW-1:0];
      v2_d   = v1_q;
      ov_d   = 1'b0;
    end
    if (take) begin
      if (last) begin
        i_d     = res_i;
        q_d     = res_q;
        ovf_d   = sat_w_q | sat_i | sat_q;
        ov_d    = 1'b1;
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
        sat_w_d = 1'b0;
        len_d   = (dec_len == '0) ? CNTW'(1) : dec_len;
      end else begin
        acc_i_d = res_i;
        acc_q_d = res_q;
        cnt_d   = cnt_q + CNTW'(1);
        sat_w_d = sat_w_q | sat_i | sat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_q   <= '0;
      fsin_q  <= '0;
      fcos_q  <= '0;
      v1_q    <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
      v2_q    <= 1'b0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      len_q   <= CNTW'(DEC_N);
      sat_w_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      adc_q   <= adc_d;
      fsin_q  <= fsin_d;
      fcos_q  <= fcos_d;
      v1_q    <= v1_d;
      pi_q    <= pi_d;
      pq_q    <= pq_d;
      v2_q    <= v2_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_w_q <= sat_w_d;
      i_q     <= i_d;
      q_q     <= q_d;
      ov_q    <= ov_d;
      ovf_q   <= ovf_d;
    end
  end

  assign i_o       = i_q;
  assign q_o       = q_q;
  assign out_valid = ov_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_iq_mix_integrate.sv
// Bench for iq_mix_integrate: a 32-bit-accumulator instance and a 16-bit one (to reach saturation)
// share stimulus and are checked every cycle against a sample-queue reference model.
module tb_iq_mix_integrate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clken, nco_valid;
  logic signed [13:0] adc, fs, fc;
  logic [15:0] dec_len;
  logic signed [31:0] i32, q32;
  logic signed [15:0] i16, q16;
  logic v32, o32, v16, o16;

  iq_mix_integrate #(.ACCW(32), .DEC_N(4)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .adc_i(adc), .fsin_i(fs), .fcos_i(fc),
    .nco_valid(nco_valid), .dec_len(dec_len), .i_o(i32), .q_o(q32), .out_valid(v32), .ovf_o(o32));

  iq_mix_integrate #(.ACCW(16), .DEC_N(8)) dut16 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .adc_i(adc), .fsin_i(fs), .fcos_i(fc),
    .nco_valid(nco_valid), .dec_len(dec_len), .i_o(i16), .q_o(q16), .out_valid(v16), .ovf_o(o16));

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples wait in a queue tagged with their enabled-edge index
  // and are summed two enabled edges later; windows close on sample count.
  typedef struct {int e; int a; int s; int c;} samp_t;
  samp_t pipe[$];
  int en_edge = 0;
  localparam int AW [2]   = '{32, 16};
  localparam int DECN [2] = '{4, 8};
  longint m_acc_i[2], m_acc_q[2], m_out_i[2], m_out_q[2];
  int m_cnt[2], m_len[2];
  bit m_satw[2], m_v[2], m_ovf[2];

  task automatic model_reset();
    pipe.delete();
    for (int j = 0; j < 2; j++) begin
      m_acc_i[j] = 0; m_acc_q[j] = 0; m_out_i[j] = 0; m_out_q[j] = 0;
      m_cnt[j] = 0; m_len[j] = DECN[j]; m_satw[j] = 0; m_v[j] = 0; m_ovf[j] = 0;
    end
  endtask

  task automatic model_edge();
    samp_t sm;
    longint pi, pq, si, sq, mx, mn;
    bit sti, stq;
    if (!clken) return;
    en_edge++;
    for (int j = 0; j < 2; j++) m_v[j] = 0;
    if (pipe.size() > 0 && pipe[0].e == en_edge - 2) begin
      sm = pipe.pop_front();
      pi = longint'(sm.a * sm.c) >>> 13;
      pq = longint'(sm.a * sm.s) >>> 13;
      for (int j = 0; j < 2; j++) begin
        mx = (longint'(1) <<< (AW[j] - 1)) - 1;
        mn = -mx - 1;
        si = m_acc_i[j] + pi;
        sq = m_acc_q[j] + pq;
        sti = (si > mx) || (si < mn);
        stq = (sq > mx) || (sq < mn);
        si = (si > mx) ? mx : (si < mn) ? mn : si;
        sq = (sq > mx) ? mx : (sq < mn) ? mn : sq;
        if (m_cnt[j] + 1 == m_len[j]) begin
          m_out_i[j] = si; m_out_q[j] = sq;
          m_ovf[j] = m_satw[j] | sti | stq;
          m_v[j] = 1;
          m_acc_i[j] = 0; m_acc_q[j] = 0; m_cnt[j] = 0; m_satw[j] = 0;
          m_len[j] = (dec_len == 0) ? 1 : int'(dec_len);
        end else begin
          m_acc_i[j] = si; m_acc_q[j] = sq;
          m_cnt[j]++;
          m_satw[j] = m_satw[j] | sti | stq;
        end
      end
    end
    if (nco_valid) pipe.push_back('{en_edge, int'(adc), int'(fs), int'(fc)});
  endtask

  function automatic logic [99:0] exp_vec();
    longint a, b, c, d;
    a = m_out_i[0]; b = m_out_q[0]; c = m_out_i[1]; d = m_out_q[1];
    return {a[31:0], b[31:0], m_v[0], m_ovf[0], c[15:0], d[15:0], m_v[1], m_ovf[1]};
  endfunction

  function automatic logic [99:0] obs_vec();
    return {i32, q32, v32, o32, i16, q16, v16, o16};
  endfunction

  task automatic tick(input bit ce, input bit nv, input int a, input int s, input int c);
    clken = ce; nco_valid = nv;
    adc = 14'(a); fs = 14'(s); fc = 14'(c);
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 100'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clken = 1'b0; nco_valid = 1'b0;
    adc = '0; fs = '0; fc = '0; dec_len = 16'd4;
    model_reset();
    #2;
    checks++;
    if (obs_vec() !== 100'b0) begin
      errors++;
      $display("FAIL power_on_reset: got %h want 0", obs_vec());
    end
    do_reset();
  endtask

  task automatic test_full_scale();
    int dumps = 0;
    dec_len = 16'd4;
    for (int n = 0; n < 20; n++) begin
      tick(1, 1, 8191, 0, 8191);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_scale cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v32) begin
        dumps++;
        checks++;
        if (i32 !== 32'sd32760 || q32 !== 32'sd0 || o32 !== 1'b0) begin
          errors++;
          $display("FAIL full_scale_value: got i=%0d q=%0d ovf=%0b want i=32760 q=0 ovf=0", i32, q32, o32);
        end
      end
    end
    checks++;
    if (dumps !== 4) begin
      errors++;
      $display("FAIL full_scale_dumps: got %0d want 4", dumps);
    end
  endtask

  task automatic test_negative();
    int dumps = 0;
    do_reset();
    dec_len = 16'd4;
    for (int n = 0; n < 12; n++) begin
      tick(1, 1, -8192, -8192, 8191);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL negative cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v32) begin
        dumps++;
        checks++;
        if (i32 !== -32'sd32764 || q32 !== 32'sd32768) begin
          errors++;
          $display("FAIL negative_value: got i=%0d q=%0d want i=-32764 q=32768", i32, q32);
        end
      end
    end
    checks++;
    if (dumps !== 2) begin
      errors++;
      $display("FAIL negative_dumps: got %0d want 2", dumps);
    end
  endtask

  task automatic test_saturation();
    int d16 = 0;
    do_reset();
    dec_len = 16'd8;
    for (int n = 0; n < 20; n++) begin
      tick(1, 1, (n < 8) ? -8192 : 0, 0, -8192);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v16) begin
        checks++;
        if (d16 == 0 && (i16 !== 16'sd32767 || o16 !== 1'b1)) begin
          errors++;
          $display("FAIL sat_window: got i=%0d ovf=%0b want i=32767 ovf=1", i16, o16);
        end else if (d16 == 1 && (i16 !== 16'sd0 || o16 !== 1'b0)) begin
          errors++;
          $display("FAIL sat_clear_window: got i=%0d ovf=%0b want i=0 ovf=0", i16, o16);
        end
        d16++;
      end
    end
    checks++;
    if (d16 !== 2) begin
      errors++;
      $display("FAIL sat_dumps: got %0d want 2", d16);
    end
  endtask

  task automatic test_gaps();
    int low_at [5];
    bit ce;
    do_reset();
    dec_len = 16'd4;
    for (int k = 0; k < 5; k++) low_at[k] = int'($urandom_range(2, 57));
    for (int n = 0; n < 60; n++) begin
      ce = 1'b1;
      for (int k = 0; k < 5; k++) if (low_at[k] == n) ce = 1'b0;
      tick(ce, n[0] == 1'b0, 8191, 0, 8191);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gaps cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v32) begin
        checks++;
        if (i32 !== 32'sd32760 || q32 !== 32'sd0) begin
          errors++;
          $display("FAIL gaps_value: got i=%0d q=%0d want i=32760 q=0", i32, q32);
        end
      end
    end
  endtask

  task automatic test_len_change();
    int first_dump = -1;
    do_reset();
    dec_len = 16'd4;
    for (int n = 0; n < 14; n++) begin
      if (n == 2) dec_len = 16'd2;
      tick(1, 1, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 16383)) - 8192);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL len_change cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    tick(1, 1, 1000, 2000, 3000);
    do_reset();
    dec_len = 16'd2;
    for (int n = 1; n <= 8; n++) begin
      tick(1, 1, 1000, 2000, 3000);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v32 && first_dump < 0) first_dump = n;
    end
    checks++;
    if (first_dump !== 6) begin
      errors++;
      $display("FAIL post_reset_window: first dump at cycle %0d want 6", first_dump);
    end
  endtask

  task automatic test_dec_len_zero();
    int dumps = 0;
    do_reset();
    dec_len = 16'd0;
    for (int n = 0; n < 20; n++) begin
      tick(1, 1, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 16383)) - 8192);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL dec_len_zero cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (v32) dumps++;
    end
    checks++;
    if (dumps !== 15) begin
      errors++;
      $display("FAIL dec_len_zero_dumps: got %0d want 15", dumps);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) dec_len = 16'($urandom_range(0, 5));
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 16383)) - 8192);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_negative();
    test_saturation();
    test_gaps();
    test_len_change();
    test_dec_len_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_mix_integrate.md
# iq_mix_integrate

Downstream consumer of the NCO sine/cosine outputs in the synchronous IQ demodulator. The block multiplies each ADC sample by the NCO's `fcos`/`fsin` words to produce in-phase and quadrature products, truncates each product to the 15-bit mixing width, and then integrate-and-dumps over a programmable window. It emits one decimated I/Q pair per window, with a valid strobe and a saturation flag, to the downstream magnitude/phase logic.

## Interface
- `MPR`, 14: NCO output width (signed two's complement).
- `DW`, 14: ADC sample width (signed).
- `MW`, 15: retained mixing-product width.
- `ACCW`, 32: accumulator and output width.
- `CNTW`, 16: window-length width.
- `DEC_N`, 1024: window length used out of reset.

Ports:
- `clk`  in  1  single system clock.
- `reset_n`  in  1  reset, asynchronous, active-low; the block has one clock.
- `clken`  in  1  global clock enable, same signal as the NCO's `clken`.
- `adc_i`  in  DW  ADC sample, aligned by upstream logic to the NCO output.
- `fsin_i`  in  MPR  NCO sine.
- `fcos_i`  in  MPR  NCO cosine.
- `nco_valid`  in  1  NCO `out_valid`; a sample is accepted only when it is high.
- `dec_len`  in  CNTW  samples per window; 0 is treated as 1.
- `i_o`  out  ACCW  integrated in-phase result.
- `q_o`  out  ACCW  integrated quadrature result.
- `out_valid`  out  1  one-cycle strobe marking a new `i_o`/`q_o`.
- `ovf_o`  out  1  set if the window just dumped saturated on I or Q.

## Operation
- **Accept rule.** A sample is accepted when `clken & nco_valid`. When `clken` is 0, every register holds its value, including the valid pipeline bits.
- **S1 (input register).** Registers `adc_i`, `fsin_i` and `fcos_i`, plus a valid bit.
- **S2 (multiply).**
  - Computes `adc*fcos` → I and `adc*fsin` → Q as full signed (DW+MPR)-bit products.
  - Each product is arithmetic-shifted right by (DW+MPR−MW), i.e. floor truncation, with no rounding.
  - The MW-bit result is registered, together with a valid bit.
- **S3 (accumulate/dump).**
  - On each valid S2 entry, both accumulators add the sign-extended product, with saturation at ±(2^(ACCW−1)) limits: max = 2^(ACCW−1)−1, min = −2^(ACCW−1).
  - Any saturation on either channel sets an internal sticky bit `sat_w`.
  - Counter `cnt` increments per valid entry.
  - When `cnt == len_l−1` on a valid entry, the block performs a dump:
    - `i_o`/`q_o` ← acc + product (saturated);
    - `ovf_o` ← `sat_w` OR saturation on this add;
    - `out_valid` = 1;
    - both accumulators ← 0, `cnt` ← 0, `sat_w` ← 0;
    - `len_l` ← max(`dec_len`, 1).
- **Window length.** `len_l` is latched only at a dump, so a change to `dec_len` mid-window takes effect from the next window.
- **Outputs between dumps.** `i_o`, `q_o` and `ovf_o` hold their last dumped values.
- **Bubbles.** Cycles with `nco_valid` = 0 travel through S1/S2 as bubbles and do not advance `cnt`.

## Timing
- **Reset values.** `i_o` = 0, `q_o` = 0, `out_valid` = 0, `ovf_o` = 0, accumulators = 0, `cnt` = 0, `len_l` = `DEC_N`.
- **Reset mid-window.** Asserting reset mid-window discards partial sums. The first window after release has length `DEC_N`, not `dec_len`.
- **Latency.** A sample accepted at enabled cycle k appears in the S3 sum at enabled cycle k+2. If it is the last sample of its window, `out_valid` is high during enabled cycle k+3.
- **Strobe width.** `out_valid` is high for exactly one enabled cycle. If `clken` drops while it is high, it stays high until the next enabled edge clears it.
- **Throughput.** One sample per enabled cycle. With `dec_len` = 1, every accepted sample produces a dump, and `out_valid` may be high on consecutive cycles.
- **Simultaneous dump and new product.** The dump cycle's product is included in the dumped value. The next product starts the new window from 0.

## Test plan
- **Positive full-scale.**
  - Stimulus: `dec_len` = 4 (after one `DEC_N`-length window, or with `DEC_N` = 4); `adc_i` = 8191, `fcos_i` = 8191, `fsin_i` = 0; `nco_valid` = 1 continuous.
  - Required response: products I = 8190, Q = 0; each dump gives `i_o` = 32760, `q_o` = 0, `ovf_o` = 0; `out_valid` every 4 cycles.
- **Negative value.**
  - Stimulus: `adc_i` = −8192, `fcos_i` = 8191, `fsin_i` = −8192, `dec_len` = 4.
  - Required response: `i_o` = −32764, `q_o` = 32768.
- **Saturation.**
  - Stimulus: `ACCW` = 16, `adc_i` = `fcos_i` = −8192, `dec_len` = 8.
  - Required response: `i_o` = 32767, `ovf_o` = 1. The following window with `adc_i` = 0 must give `i_o` = 0, `ovf_o` = 0.
- **Gaps.**
  - Stimulus: `nco_valid` toggling 1,0,1,0… and `clken` low for 5 random cycles, `dec_len` = 4.
  - Required response: dump values identical to the continuous case; `out_valid` exactly 3 enabled cycles after the 4th accepted sample.
- **Length change and reset.**
  - Stimulus: `dec_len` changed 4→2 mid-window; separately, `reset_n` pulsed low mid-window.
  - Required response: the current window still dumps after 4 samples, then windows of 2. After the reset, all outputs are 0 and the next dump occurs after `DEC_N` samples.
- **`dec_len` = 0.**
  - Stimulus: `dec_len` = 0.
  - Required response: behaves as 1, with a dump on every accepted sample.
